// File: rtl/spike_aer_arbiter.sv
// spike_aer_arbiter: latches one-cycle neuron spike pulses as pending events and
// serializes them onto a single AER valid/ready channel with round-robin grant.
// Spikes that hit an already-pending, non-granted neuron are dropped and counted.
module spike_aer_arbiter #(
    parameter int N_NEURON = 8,
    parameter int ADDR_W   = $clog2(N_NEURON),
    parameter int DROP_W   = 8
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [N_NEURON-1:0] spike_in,
    output logic                aer_valid,
    input  logic                aer_ready,
    output logic [ADDR_W-1:0]   aer_addr,
    output logic                busy,
    output logic [DROP_W-1:0]   drop_cnt,
    input  logic                drop_clr
);

    // Drop sum is widened so a multi-neuron popcount cannot wrap before saturation.
    localparam int SUM_W = DROP_W + $clog2(N_NEURON + 1);
    localparam logic [SUM_W-1:0]  DROP_MAX = SUM_W'({DROP_W{1'b1}});
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_NEURON - 1);

    logic [N_NEURON-1:0] pend_q, pend_d;
    logic                valid_q, valid_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   last_q, last_d;
    logic [DROP_W-1:0]   drop_q, drop_d;

    logic                slot_free;
    logic                found;
    logic [ADDR_W-1:0]   grant_idx;
    logic [ADDR_W-1:0]   cand;
    logic [N_NEURON-1:0] grant_oh;
    logic [N_NEURON-1:0] drop_vec;
    logic [SUM_W-1:0]    drop_sum;

    assign slot_free = !valid_q || aer_ready;

    // Round-robin search over registered pending bits, starting after last grant
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        cand      = last_q;
        for (int unsigned k = 0; k < N_NEURON; k++) begin
            cand = (cand == LAST_IDX) ? '0 : cand + ADDR_W'(1);
            if (!found && pend_q[cand]) begin
                found     = 1'b1;
                grant_idx = cand;
            end
        end
    end

    // Pending, drop accounting and output-register next state
    always_comb begin
        grant_oh = '0;
        if (slot_free && found) begin
            grant_oh[grant_idx] = 1'b1;
        end

        // A spike on a neuron being granted this cycle re-arms it instead of dropping.
        drop_vec = spike_in & pend_q & ~grant_oh;
        pend_d   = (pend_q & ~(grant_oh & ~spike_in)) | spike_in;

        drop_sum = SUM_W'(drop_q);
        for (int unsigned i = 0; i < N_NEURON; i++) begin
            drop_sum = drop_sum + SUM_W'(drop_vec[i]);
        end

        if (drop_clr) begin
            drop_d = '0;
        end else if (drop_sum > DROP_MAX) begin
            drop_d = '1;
        end else begin
            drop_d = drop_sum[DROP_W-1:0];
        end

        valid_d = valid_q;
        addr_d  = addr_q;
        last_d  = last_q;
        if (slot_free) begin
            valid_d = found;
            if (found) begin
                addr_d = grant_idx;
                last_d = grant_idx;
            end
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pend_q  <= '0;
            valid_q <= 1'b0;
            addr_q  <= '0;
            last_q  <= LAST_IDX;
            drop_q  <= '0;
        end else begin
            pend_q  <= pend_d;
            valid_q <= valid_d;
            addr_q  <= addr_d;
            last_q  <= last_d;
            drop_q  <= drop_d;
        end
    end

    assign aer_valid = valid_q;
    assign aer_addr  = addr_q;
    assign drop_cnt  = drop_q;
    assign busy      = (|pend_q) || valid_q;

endmodule

// File: tb/tb_spike_aer_arbiter.sv
// Self-checking bench for spike_aer_arbiter: an event-level reference model is
// compared against the DUT every cycle, and directed scenarios check accepted
// event sequences and key values against hand-computed literals.
module tb_spike_aer_arbiter;

    localparam int N = 8;
    localparam int AW = 3;
    localparam int DW = 8;
    localparam int DMAX = 255;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [N-1:0]  spike_in = '0;
    logic          aer_ready = 1'b0;
    logic          drop_clr = 1'b0;
    logic          aer_valid;
    logic [AW-1:0] aer_addr;
    logic          busy;
    logic [DW-1:0] drop_cnt;

    int checks = 0;
    int errors = 0;

    spike_aer_arbiter #(.N_NEURON(N), .ADDR_W(AW), .DROP_W(DW)) dut (
        .clk(clk), .rstn(rstn), .spike_in(spike_in),
        .aer_valid(aer_valid), .aer_ready(aer_ready), .aer_addr(aer_addr),
        .busy(busy), .drop_cnt(drop_cnt), .drop_clr(drop_clr)
    );

    always #5 clk = ~clk;

    // Reference model: set of waiting neurons, the event on the channel, and
    // the neuron served last; everything in plain integers.
    int m_pend[N];
    int m_valid, m_addr, m_last, m_cnt;
    int m_log[$];
    int dut_log[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < N; i++) m_pend[i] = 0;
            m_valid = 0; m_addr = 0; m_last = N - 1; m_cnt = 0;
        end else begin
            int g, drops;
            bit free;
            free = (m_valid == 0) || aer_ready;
            if (m_valid != 0 && aer_ready) m_log.push_back(m_addr);
            g = -1;
            if (free) begin
                for (int k = 1; k <= N && g < 0; k++)
                    if (m_pend[(m_last + k) % N] != 0) g = (m_last + k) % N;
            end
            drops = 0;
            for (int i = 0; i < N; i++) begin
                if (spike_in[i]) begin
                    if (m_pend[i] != 0 && i != g) drops++;
                    m_pend[i] = 1;
                end else if (i == g) begin
                    m_pend[i] = 0;
                end
            end
            if (free) begin
                m_valid = (g >= 0) ? 1 : 0;
                if (g >= 0) begin m_addr = g; m_last = g; end
            end
            if (drop_clr) m_cnt = 0;
            else m_cnt = (m_cnt + drops > DMAX) ? DMAX : m_cnt + drops;
        end
    end

    // Per-cycle comparison and accepted-event capture, mid-cycle
    always @(negedge clk) begin
        int any;
        any = 0;
        for (int i = 0; i < N; i++) any |= m_pend[i];
        chk("aer_valid", int'(aer_valid), m_valid);
        chk("aer_addr", int'(aer_addr), m_addr);
        chk("busy", int'(busy), (any != 0 || m_valid != 0) ? 1 : 0);
        chk("drop_cnt", int'(drop_cnt), m_cnt);
        if (rstn && aer_valid && aer_ready) dut_log.push_back(int'(aer_addr));
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rstn = 1'b0; spike_in = '0; aer_ready = 1'b0; drop_clr = 1'b0;
        tick(2);
        rstn = 1'b1;
        dut_log.delete();
        m_log.delete();
    endtask

    task automatic check_seq(input string name, input int exp[$]);
        chk({name, "_dut_len"}, dut_log.size(), exp.size());
        chk({name, "_model_len"}, m_log.size(), exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            if (i < dut_log.size()) chk({name, "_dut_addr"}, dut_log[i], exp[i]);
            if (i < m_log.size()) chk({name, "_model_addr"}, m_log[i], exp[i]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp[$];

        // Reset state
        do_reset();
        chk("rst_valid", int'(aer_valid), 0);
        chk("rst_addr", int'(aer_addr), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_drop", int'(drop_cnt), 0);

        // Single event: two edges of latency, one valid cycle
        aer_ready = 1'b1; spike_in = 8'h08;
        tick();
        spike_in = '0;
        chk("single_lat_valid", int'(aer_valid), 0);
        tick();
        chk("single_valid", int'(aer_valid), 1);
        chk("single_addr", int'(aer_addr), 3);
        tick();
        chk("single_after_valid", int'(aer_valid), 0);
        chk("single_after_busy", int'(busy), 0);
        tick(2);
        exp = '{3};
        check_seq("single", exp);
        chk("single_drop", int'(drop_cnt), 0);

        // Burst of all neurons from reset: served 0..7 back to back
        do_reset();
        aer_ready = 1'b1; spike_in = 8'hFF;
        tick();
        spike_in = '0;
        tick(11);
        exp = '{0, 1, 2, 3, 4, 5, 6, 7};
        check_seq("burst", exp);
        chk("burst_drop", int'(drop_cnt), 0);
        chk("burst_model_drop", m_cnt, 0);

        // Round-robin after serving neuron 1 with {0,2,6} waiting
        do_reset();
        aer_ready = 1'b1; spike_in = 8'h02;
        tick();
        spike_in = 8'h45;
        tick();
        spike_in = '0;
        tick(8);
        exp = '{1, 2, 6, 0};
        check_seq("rr", exp);

        // Backpressure: repeated spikes on neuron 5 with the channel stalled
        do_reset();
        aer_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            spike_in = (c % 2 == 0 && c <= 4) ? 8'h20 : 8'h00;
            tick();
        end
        spike_in = '0;
        chk("bp_valid", int'(aer_valid), 1);
        chk("bp_addr", int'(aer_addr), 5);
        chk("bp_busy", int'(busy), 1);
        chk("bp_drop", int'(drop_cnt), 1);
        chk("bp_model_drop", m_cnt, 1);
        aer_ready = 1'b1;
        tick(6);
        exp = '{5, 5};
        check_seq("bp", exp);

        // Saturation and clear (clear beats same-cycle drops)
        do_reset();
        aer_ready = 1'b0; spike_in = 8'h01;
        tick(302);
        chk("sat_drop", int'(drop_cnt), 255);
        chk("sat_model_drop", m_cnt, 255);
        drop_clr = 1'b1;
        tick();
        chk("clr_prio_drop", int'(drop_cnt), 0);
        drop_clr = 1'b0;
        tick();
        chk("after_clr_drop", int'(drop_cnt), 1);
        spike_in = '0;
        drop_clr = 1'b1;
        tick();
        drop_clr = 1'b0;
        chk("clr_drop", int'(drop_cnt), 0);

        // Asynchronous reset mid-cycle with an event out and two pending
        do_reset();
        aer_ready = 1'b0; spike_in = 8'h31;
        tick();
        spike_in = '0;
        tick();
        chk("mid_valid_pre", int'(aer_valid), 1);
        chk("mid_addr_pre", int'(aer_addr), 0);
        chk("mid_busy_pre", int'(busy), 1);
        #2;
        rstn = 1'b0;
        #1;
        chk("mid_valid_rst", int'(aer_valid), 0);
        chk("mid_busy_rst", int'(busy), 0);
        chk("mid_addr_rst", int'(aer_addr), 0);
        tick();
        rstn = 1'b1;
        dut_log.delete();
        m_log.delete();
        aer_ready = 1'b1;
        tick(10);
        exp = {};
        check_seq("post_rst", exp);
        chk("post_rst_busy", int'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
